// File: rtl/mem_stage_ctrl_pkg.sv
// rtl/mem_stage_ctrl_pkg.sv - shared types and helpers for the memory-stage controller
//
// Contents:
//   state_t      controller FSM states (3-bit encoding)
//   align_mask   low-address bits that must be zero for a DATA_W access
//   sat_inc      saturating increment for counters up to 64 bits wide
package mem_stage_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_DUMP   = 3'd4,
    S_HALTED = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // One byte lane per 8 data bits; an access is aligned when the byte
  // offset within the word is zero. DATA_W=8 yields a zero mask.
  function automatic int unsigned align_mask(input int unsigned data_w);
    return (data_w / 8) - 1;
  endfunction

  // Counters narrower than 64 bits are zero-extended by the caller;
  // the all-ones value of the real width is the saturation point.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (value == max_val) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - bus between the memory-stage controller and mem_system
//
// Signals:
//   mem_addr, mem_wdata          latched address / store data (controller -> memory)
//   mem_rd, mem_wr               one-cycle access strobes
//   mem_createdump               one-cycle dump strobe
//   mem_dataout                  read data (memory -> controller)
//   mem_done, mem_hit            completion and hit flag (hit valid with done)
//   mem_stall                    memory busy, informational
// Modports: master = controller side, slave = mem_system side.
interface mem_stage_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_createdump;
  logic [DATA_W-1:0] mem_dataout;
  logic              mem_done;
  logic              mem_stall;
  logic              mem_hit;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr, mem_createdump,
    input  mem_dataout, mem_done, mem_stall, mem_hit
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr, mem_createdump,
    output mem_dataout, mem_done, mem_stall, mem_hit
  );
endinterface

// File: rtl/mem_stage_ctrl_sat_counter.sv
// rtl/mem_stage_ctrl_sat_counter.sv - saturating event counter
//
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-low clear
//   inc   in   count one event this cycle
//   cnt   out  CNT_W-bit count, holds at all-ones
module sat_counter
  import mem_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= CNT_W'(sat_inc(64'(cnt), CNT_W));
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage controller in front of a multi-cycle mem_system
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_rd, req_wr           load / store request (both high = store)
//   req_addr, req_wdata      byte address and store data
//   halt                     request a createdump, then stop for good
//   rdata                    registered load data
//   done, stall              access complete / pipeline must freeze
//   err                      sticky misalignment or timeout error
//   mem                      mem_stage_ctrl_if master port to mem_system
//   acc_cnt, hit_cnt         saturating completed-access / hit counters
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 63,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              halt,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              stall,
  output logic              err,
  mem_stage_ctrl_if.master  mem,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(DATA_W));

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              is_wr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [TCW-1:0]    tcnt, tcnt_d, tcnt_inc;

  logic req_any, misaligned;
  logic accept, capture, set_err;
  logic rd_stb, wr_stb, dump_stb;

  // mem_stall only mirrors mem_system's internal busy state; the
  // controller relies solely on mem_done.
  logic unused_mem_stall;
  assign unused_mem_stall = mem.mem_stall;

  assign req_any    = req_rd | req_wr;
  assign misaligned = |(req_addr & ALIGN_MASK);
  assign tcnt_inc   = tcnt + TCW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tcnt    <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        is_wr_q <= req_wr;   // rd+wr together is treated as a store
      end
      if (capture && !is_wr_q) begin
        rdata_q <= mem.mem_dataout;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_d    = tcnt;
    accept    = 1'b0;
    capture   = 1'b0;
    set_err   = 1'b0;
    done      = 1'b0;
    stall     = 1'b0;
    rd_stb    = 1'b0;
    wr_stb    = 1'b0;
    dump_stb  = 1'b0;

    case (state)
      S_IDLE: begin
        done  = ~req_any;
        stall = req_any;
        if (halt) begin
          state_nxt = S_DUMP;
        end else if (req_any) begin
          if (misaligned) begin
            set_err   = 1'b1;
            state_nxt = S_ERROR;
          end else begin
            accept    = 1'b1;
            state_nxt = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        stall  = 1'b1;
        rd_stb = ~is_wr_q;
        wr_stb = is_wr_q;
        tcnt_d = '0;
        if (mem.mem_done) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end else begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        stall = 1'b1;
        if (mem.mem_done) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end else if (tcnt_inc == TCW'(TIMEOUT)) begin
          // this WAIT cycle is the TIMEOUT-th without completion
          set_err   = 1'b1;
          state_nxt = S_ERROR;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end

      S_RESP: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      S_DUMP: begin
        stall     = 1'b1;
        dump_stb  = 1'b1;
        state_nxt = S_HALTED;
      end

      S_HALTED: begin
        done = 1'b1;
      end

      S_ERROR: begin
        done = 1'b1;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign rdata              = rdata_q;
  assign err                = err_q;
  assign mem.mem_addr       = addr_q;
  assign mem.mem_wdata      = wdata_q;
  assign mem.mem_rd         = rd_stb;
  assign mem.mem_wr         = wr_stb;
  assign mem.mem_createdump = dump_stb;

  sat_counter #(.CNT_W(CNT_W)) u_acc_cnt (
    .clk (clk),
    .rst (rst),
    .inc (capture),
    .cnt (acc_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (capture & mem.mem_hit),
    .cnt (hit_cnt)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed scoreboard bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 63;
  localparam int CNT_W   = 2;

  typedef struct {
    logic [15:0] rdata;
    logic [1:0]  acc;
    logic [1:0]  hit;
    int          lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_rd, req_wr, halt;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rdata;
  logic              done, stall, err;
  logic [CNT_W-1:0]  acc_cnt, hit_cnt;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  logic [15:0] m_rdata;
  logic [1:0]  m_acc, m_hit;

  mem_stage_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_stage_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_rd   (req_rd),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .halt     (halt),
    .rdata    (rdata),
    .done     (done),
    .stall    (stall),
    .err      (err),
    .mem      (bus.master),
    .acc_cnt  (acc_cnt),
    .hit_cnt  (hit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sat2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  task automatic clear_inputs();
    req_rd = 1'b0; req_wr = 1'b0; halt = 1'b0;
    req_addr = '0; req_wdata = '0;
    bus.mem_done = 1'b0; bus.mem_hit = 1'b0; bus.mem_stall = 1'b0;
    bus.mem_dataout = 16'hDEAD;
  endtask

  // Assert reset off-edge, hold it across one rising edge, release it.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_rdata = '0; m_acc = '0; m_hit = '0;
  endtask

  task automatic wait_cycle();
    @(posedge clk); #1;
  endtask

  // One access: model result pushed at stimulus time, popped when the DUT
  // shows RESP. mem_done is raised nwait cycles after the ISSUE cycle.
  task automatic do_access(input string tag, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] dout,
                           input logic hit, input int nwait);
    exp_t e, got;
    int   n_rd, n_wr;
    bit   seen;
    if (!wr) m_rdata = dout;
    m_acc = sat2(m_acc);
    if (hit) m_hit = sat2(m_hit);
    e.rdata = m_rdata; e.acc = m_acc; e.hit = m_hit; e.lat = nwait + 2;
    sb.push_back(e);

    req_rd = ~wr; req_wr = wr; req_addr = addr; req_wdata = wdata;
    #4;
    check($sformatf("%s accept_stall", tag), 32'(stall), 32'd1);
    wait_cycle();
    req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;

    n_rd = 0; n_wr = 0; seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      bus.mem_done    = (k == nwait);
      bus.mem_hit     = hit & (k == nwait);
      bus.mem_dataout = (k == nwait) ? dout : 16'hDEAD;
      #4;
      n_rd += int'(bus.mem_rd);
      n_wr += int'(bus.mem_wr);
      if (bus.mem_rd | bus.mem_wr) begin
        check($sformatf("%s mem_addr", tag), 32'(bus.mem_addr), 32'(addr));
        if (wr) check($sformatf("%s mem_wdata", tag), 32'(bus.mem_wdata), 32'(wdata));
      end
      if (done && !stall) begin
        seen = 1'b1;
        got  = sb.pop_front();
        check($sformatf("%s latency", tag), 32'(k + 1), 32'(got.lat));
        check($sformatf("%s rdata", tag), 32'(rdata), 32'(got.rdata));
        check($sformatf("%s acc_cnt", tag), 32'(acc_cnt), 32'(got.acc));
        check($sformatf("%s hit_cnt", tag), 32'(hit_cnt), 32'(got.hit));
      end
      wait_cycle();
      bus.mem_done = 1'b0; bus.mem_hit = 1'b0; bus.mem_dataout = 16'hDEAD;
    end
    check($sformatf("%s resp_seen", tag), 32'(seen), 32'd1);
    check($sformatf("%s rd_strobes", tag), 32'(n_rd), 32'(!wr));
    check($sformatf("%s wr_strobes", tag), 32'(n_wr), 32'(wr));
  endtask

  initial begin
    int n_rd, n_wr, n_dump, first_err, stall_at_err;

    clear_inputs();
    rst = 1'b0;
    #3;
    check("reset done", 32'(done), 32'd1);
    check("reset stall", 32'(stall), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset acc", 32'(acc_cnt), 32'd0);
    check("reset strobes", 32'({bus.mem_rd, bus.mem_wr, bus.mem_createdump}), 32'd0);
    do_reset();

    // same-cycle hit load, then a miss store with 4 WAIT cycles
    do_access("hit_load", 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, 0);
    do_access("miss_store", 1'b1, 16'h0020, 16'h1234, 16'h7777, 1'b0, 4);
    do_access("miss_load", 1'b0, 16'h0022, 16'h0000, 16'hC0DE, 1'b0, 2);

    // misaligned load goes straight to ERROR, never reaching memory
    req_rd = 1'b1; req_addr = 16'h0003;
    #4;
    wait_cycle();
    n_rd = 0;
    for (int k = 0; k < 4; k++) begin
      req_rd = 1'b1; req_addr = 16'h0004;
      #4;
      n_rd += int'(bus.mem_rd);
      if (k == 0) begin
        check("misalign err", 32'(err), 32'd1);
        check("misalign done", 32'(done), 32'd1);
        check("misalign stall", 32'(stall), 32'd0);
      end
      wait_cycle();
    end
    check("misalign no_rd", 32'(n_rd), 32'd0);
    check("misalign err_held", 32'(err), 32'd1);
    do_reset();
    check("post_reset err", 32'(err), 32'd0);

    // timeout: mem_done never arrives
    req_rd = 1'b1; req_addr = 16'h0040;
    #4;
    wait_cycle();
    req_rd = 1'b0;
    first_err = -1; stall_at_err = -1; n_rd = 0;
    for (int k = 0; k < 200 && first_err < 0; k++) begin
      #4;
      n_rd += int'(bus.mem_rd);
      if (err) begin
        first_err    = k;
        stall_at_err = int'(stall);
      end
      wait_cycle();
    end
    check("timeout err_cycle", 32'(first_err), 32'd64);
    check("timeout stall", 32'(stall_at_err), 32'd0);
    check("timeout rd_strobes", 32'(n_rd), 32'd1);
    do_reset();

    // halt beats a simultaneous store request
    halt = 1'b1; req_wr = 1'b1; req_addr = 16'h0030; req_wdata = 16'hAAAA;
    #4;
    wait_cycle();
    halt = 1'b0;
    n_dump = 0; n_wr = 0; n_rd = 0;
    for (int k = 0; k < 6; k++) begin
      req_wr = (k < 3); req_rd = (k >= 3);
      #4;
      n_dump += int'(bus.mem_createdump);
      n_wr   += int'(bus.mem_wr);
      n_rd   += int'(bus.mem_rd);
      wait_cycle();
    end
    req_wr = 1'b0; req_rd = 1'b0;
    #4;
    check("halt dump_pulses", 32'(n_dump), 32'd1);
    check("halt no_wr", 32'(n_wr), 32'd0);
    check("halt no_rd", 32'(n_rd), 32'd0);
    check("halt done", 32'(done), 32'd1);
    check("halt stall", 32'(stall), 32'd0);
    wait_cycle();
    do_reset();

    // reset in the middle of WAIT
    do_access("pre_reset_load", 1'b0, 16'h0050, 16'h0000, 16'h5A5A, 1'b1, 1);
    req_rd = 1'b1; req_addr = 16'h0052;
    #4;
    wait_cycle();
    req_rd = 1'b0;
    wait_cycle();
    wait_cycle();
    #2;
    rst = 1'b0;
    #1;
    check("midwait_rst stall", 32'(stall), 32'd0);
    check("midwait_rst done", 32'(done), 32'd1);
    check("midwait_rst rdata", 32'(rdata), 32'd0);
    check("midwait_rst acc", 32'(acc_cnt), 32'd0);
    check("midwait_rst mem_addr", 32'(bus.mem_addr), 32'd0);
    wait_cycle();
    rst = 1'b1;
    m_rdata = '0; m_acc = '0; m_hit = '0;
    n_rd = 0;
    for (int k = 0; k < 5; k++) begin
      #4;
      n_rd += int'(bus.mem_rd);
      wait_cycle();
    end
    check("midwait_rst no_reissue", 32'(n_rd), 32'd0);

    // saturation of the 2-bit counters
    for (int i = 0; i < 5; i++) begin
      do_access($sformatf("sat%0d", i), 1'b0, 16'(16'h0100 + 2 * i), 16'h0000,
                16'(16'h1000 + i), 1'b1, i % 2);
    end
    check("sat acc_cnt", 32'(acc_cnt), 32'd3);
    check("sat hit_cnt", 32'(hit_cnt), 32'd3);
    check("sat sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
